// File: rtl/del_accum_buffer.sv
// del_accum_buffer: banked storage and read-modify-write sequencer for preceding-layer partial deltas.
// Optional macro DEL_ACC_FWD_EN forwards same-lane write-back data into stage 1 instead of stalling.
module del_accum_buffer #(
    parameter int p     = 16,
    parameter int z     = 8,
    parameter int width = 16,
    localparam int depth = p / z,
    localparam int aw    = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [z*aw-1:0]      in_addr_package,
    output logic [width*z-1:0]   partial_del_out_package,
    input  logic [width*z-1:0]   del_out_package,
    output logic                 busy,
    output logic                 done,
    input  logic [aw-1:0]        rd_addr,
    output logic [width*z-1:0]   rd_data_package
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t                 state;
    logic                   busy_q;
    logic                   done_q;

    logic [width-1:0]       mem [z][depth];
    logic [z-1:0][depth-1:0] touched;

    logic [aw-1:0]          in_addr [z];
    logic [width-1:0]       del_in  [z];

    logic                   s1_valid;
    logic [aw-1:0]          s1_addr [z];
    logic [width-1:0]       s1_data [z];
    logic [width-1:0]       rd_q    [z];

    logic [z-1:0]           lane_hit;
    logic                   accept;
    logic                   start_ok;

    for (genvar g = 0; g < z; g++) begin : g_lane
        assign in_addr[g]                             = in_addr_package[g*aw +: aw];
        assign del_in[g]                              = del_out_package[g*width +: width];
        assign partial_del_out_package[g*width +: width] = s1_data[g];
        assign rd_data_package[g*width +: width]      = rd_q[g];
    end

    always_comb begin
        lane_hit = '0;
        for (int unsigned i = 0; i < z; i++) begin
            lane_hit[i] = s1_valid && (in_addr[i] == s1_addr[i]);
        end
    end

`ifdef DEL_ACC_FWD_EN
    assign in_ready = (state == ACCUM);
`else
    // A same-lane match would read the bank before stage 1 writes it back; hold off one cycle.
    assign in_ready = (state == ACCUM) && !(in_valid && (|lane_hit));
`endif

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state == IDLE || state == DONE);
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= ACCUM;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept && in_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            touched  <= '0;
            for (int unsigned i = 0; i < z; i++) begin
                s1_addr[i] <= '0;
                s1_data[i] <= '0;
                rd_q[i]    <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int unsigned i = 0; i < z; i++) begin
                    s1_addr[i] <= in_addr[i];
`ifdef DEL_ACC_FWD_EN
                    if (lane_hit[i]) begin
                        s1_data[i] <= del_in[i];
                    end else begin
                        s1_data[i] <= touched[i][in_addr[i]] ? mem[i][in_addr[i]] : '0;
                    end
`else
                    s1_data[i] <= touched[i][in_addr[i]] ? mem[i][in_addr[i]] : '0;
`endif
                end
            end
            // Stage 1 is never valid in IDLE/DONE, so clear and set cannot collide.
            if (start_ok) begin
                touched <= '0;
            end else if (s1_valid) begin
                for (int unsigned i = 0; i < z; i++) begin
                    touched[i][s1_addr[i]] <= 1'b1;
                end
            end
            if (state == DONE) begin
                for (int unsigned i = 0; i < z; i++) begin
                    rd_q[i] <= touched[i][rd_addr] ? mem[i][rd_addr] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            for (int unsigned i = 0; i < z; i++) begin
                mem[i][s1_addr[i]] <= del_in[i];
            end
        end
    end

endmodule
